// File: rtl/conv_ctrl_seq_if.sv
// ---------------------------------------------------------------------------
// conv_ctrl_seq_if
// Bundles every non-clock/reset signal of the convolution control sequencer.
//
// Signals:
//   start                  job start pulse (environment -> controller)
//   i_/k_/b_TVALID         input, kernel and bias stream valids (in)
//   o_TREADY               output stream ready (in)
//   i_/k_/b_TREADY         stream readies (out)
//   o_TVALID, o_TLAST      output stream valid / last-of-job marker (out)
//   bias_load, mac_en      datapath strobes (out)
//   tap_idx[15:0]          current tap / kernel address (out)
//   busy, done             status: not idle / end-of-job pulse (out)
//   stall_cycles[31:0]     stall counter, present only with STALL_CNT_EN
//
// Modports:
//   master  the controller side (drives readies, strobes and status)
//   slave   the environment side (drives start, valids and o_TREADY)
//
// Optional feature macro: STALL_CNT_EN
// ---------------------------------------------------------------------------
interface conv_ctrl_seq_if;
  logic        start;
  logic        i_TVALID;
  logic        k_TVALID;
  logic        b_TVALID;
  logic        o_TREADY;
  logic        i_TREADY;
  logic        k_TREADY;
  logic        b_TREADY;
  logic        o_TVALID;
  logic        o_TLAST;
  logic        bias_load;
  logic        mac_en;
  logic [15:0] tap_idx;
  logic        busy;
  logic        done;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;

  modport master (
    input  start, i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    output i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST,
    output bias_load, mac_en, tap_idx, busy, done, stall_cycles
  );

  modport slave (
    output start, i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    input  i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST,
    input  bias_load, mac_en, tap_idx, busy, done, stall_cycles
  );
`else
  modport master (
    input  start, i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    output i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST,
    output bias_load, mac_en, tap_idx, busy, done
  );

  modport slave (
    output start, i_TVALID, k_TVALID, b_TVALID, o_TREADY,
    input  i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TLAST,
    input  bias_load, mac_en, tap_idx, busy, done
  );
`endif
endinterface

// File: rtl/conv_ctrl_seq.sv
// ---------------------------------------------------------------------------
// conv_ctrl_seq
// Convolution control sequencer. For each output value of a job it accepts
// one bias beat, TAPS joint input/kernel beat pairs, waits MAC_LAT cycles for
// the datapath to settle and then presents one result beat. NUM_OUT results
// make up one job; the last one carries o_TLAST and is followed by a
// one-cycle done pulse.
//
// Parameters:
//   TAPS     MAC terms per output value (1..65535)
//   NUM_OUT  output values per job (1..65535)
//   MAC_LAT  datapath cycles from the last mac_en to a valid result (0..15)
//
// Ports:
//   clk      clock
//   reset    asynchronous, active-high reset
//   ctrl_io  conv_ctrl_seq_if.master: start, stream handshakes, datapath
//            strobes, tap_idx, busy, done (and stall_cycles, see below)
//
// Optional feature macro: STALL_CNT_EN
//   When defined, ctrl_io.stall_cycles counts MAC cycles without a beat pair
//   and OUT cycles with back-pressure; it saturates and clears on job start.
// ---------------------------------------------------------------------------
module conv_ctrl_seq #(
  parameter int TAPS    = 9,
  parameter int NUM_OUT = 16,
  parameter int MAC_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  conv_ctrl_seq_if.master ctrl_io
);

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    OUT
  } state_t;

  localparam logic [15:0] TapLast = 16'(TAPS - 1);
  localparam logic [15:0] OutLast = 16'(NUM_OUT - 1);
  localparam logic [15:0] LatInit = 16'(MAC_LAT - 1);

  state_t      state_q, state_d;
  logic [15:0] tapCnt_q, tapCnt_d;
  logic [15:0] outCnt_q, outCnt_d;
  logic [15:0] latCnt_q, latCnt_d;
  logic        done_q, done_d;
  logic        fire;
  logic        isLast;

  // A beat pair is only taken when both streams offer data at once, so the
  // readies below are derived from this and neither stream moves alone.
  assign fire   = ctrl_io.i_TVALID & ctrl_io.k_TVALID;
  assign isLast = (outCnt_q == OutLast);

  // Status outputs: busy is purely a function of the state register, done is
  // the registered end-of-job pulse.
  assign ctrl_io.busy = (state_q != IDLE);
  assign ctrl_io.done = done_q;

  // State and counter registers. An asynchronous reset drops the job
  // immediately; because every ready is derived from IDLE-state decode, no
  // beat can be accepted while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tapCnt_q <= '0;
      outCnt_q <= '0;
      latCnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tapCnt_q <= tapCnt_d;
      outCnt_q <= outCnt_d;
      latCnt_q <= latCnt_d;
      done_q   <= done_d;
    end
  end

  // Next-state and output decode. Each state only opens the handshake it
  // owns: bias ready in BIAS, input/kernel ready in MAC, result valid in OUT.
  // bias_load and mac_en live in different states so they can never overlap.
  // The DRAIN countdown starts at MAC_LAT-1 so the first result cycle lands
  // exactly MAC_LAT+1 cycles after the last mac_en.
  always_comb begin
    state_d           = state_q;
    tapCnt_d          = tapCnt_q;
    outCnt_d          = outCnt_q;
    latCnt_d          = latCnt_q;
    done_d            = 1'b0;
    ctrl_io.i_TREADY  = 1'b0;
    ctrl_io.k_TREADY  = 1'b0;
    ctrl_io.b_TREADY  = 1'b0;
    ctrl_io.o_TVALID  = 1'b0;
    ctrl_io.o_TLAST   = 1'b0;
    ctrl_io.bias_load = 1'b0;
    ctrl_io.mac_en    = 1'b0;
    ctrl_io.tap_idx   = '0;

    case (state_q)
      IDLE: begin
        if (ctrl_io.start) begin
          outCnt_d = '0;
          state_d  = BIAS;
        end
      end

      BIAS: begin
        ctrl_io.b_TREADY = 1'b1;
        if (ctrl_io.b_TVALID) begin
          ctrl_io.bias_load = 1'b1;
          tapCnt_d          = '0;
          state_d           = MAC;
        end
      end

      MAC: begin
        ctrl_io.i_TREADY = fire;
        ctrl_io.k_TREADY = fire;
        ctrl_io.mac_en   = fire;
        ctrl_io.tap_idx  = tapCnt_q;
        if (fire) begin
          tapCnt_d = tapCnt_q + 16'd1;
          if (tapCnt_q == TapLast) begin
            if (MAC_LAT == 0) begin
              state_d = OUT;
            end else begin
              latCnt_d = LatInit;
              state_d  = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        if (latCnt_q == 16'd0) begin
          state_d = OUT;
        end else begin
          latCnt_d = latCnt_q - 16'd1;
        end
      end

      OUT: begin
        ctrl_io.o_TVALID = 1'b1;
        ctrl_io.o_TLAST  = isLast;
        if (ctrl_io.o_TREADY) begin
          if (isLast) begin
            outCnt_d = '0;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            outCnt_d = outCnt_q + 16'd1;
            state_d  = BIAS;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef STALL_CNT_EN
  logic [31:0] stallCnt_q;
  logic        stallEvent;

  assign stallEvent = ((state_q == MAC) && !fire) ||
                      ((state_q == OUT) && !ctrl_io.o_TREADY);
  assign ctrl_io.stall_cycles = stallCnt_q;

  // Stall counter: one count per cycle the sequencer waits on a stream,
  // restarted by each accepted job and held at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
    end else if ((state_q == IDLE) && ctrl_io.start) begin
      stallCnt_q <= '0;
    end else if (stallEvent && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_conv_ctrl_seq
// Self-checking bench for conv_ctrl_seq. Instance A uses TAPS=3, NUM_OUT=2,
// MAC_LAT=2 and is driven from a per-cycle vector table followed by
// hand-written reset and start-while-busy sequences. Instance B uses TAPS=1,
// NUM_OUT=1, MAC_LAT=0 for the shortest possible job. A scoreboard queue
// holds the expected o_TLAST of every result beat of instance A; entries are
// pushed when a job start is driven and popped at each output handshake.
// Define STALL_CNT_EN to also check the stall counter.
// ---------------------------------------------------------------------------
module tb_conv_ctrl_seq;

  localparam int NumOutA = 2;

  localparam logic [8:0] F_IDLE  = 9'b000000000;
  localparam logic [8:0] F_BIAS  = 9'b001001010;
  localparam logic [8:0] F_MAC   = 9'b110000110;
  localparam logic [8:0] F_MACW  = 9'b000000010;
  localparam logic [8:0] F_DRAIN = 9'b000000010;
  localparam logic [8:0] F_OUT   = 9'b000100010;
  localparam logic [8:0] F_OUTL  = 9'b000110010;
  localparam logic [8:0] F_DONE  = 9'b000000001;

  typedef struct {
    logic       start;
    logic       iv;
    logic       kv;
    logic       bv;
    logic       ordy;
    logic [8:0] flags;
    int         tap;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  int   checks = 0;
  int   errors = 0;
  int   hsA    = 0;
  logic sbQ[$];
  vec_t vecs[$];

  conv_ctrl_seq_if ifA ();
  conv_ctrl_seq_if ifB ();

  conv_ctrl_seq #(.TAPS(3), .NUM_OUT(2), .MAC_LAT(2)) dutA (
    .clk    (clk),
    .reset  (reset),
    .ctrl_io(ifA.master)
  );

  conv_ctrl_seq #(.TAPS(1), .NUM_OUT(1), .MAC_LAT(0)) dutB (
    .clk    (clk),
    .reset  (reset),
    .ctrl_io(ifB.master)
  );

  logic [8:0] flagsA;
  logic [8:0] flagsB;

  // Flag order: i_TREADY k_TREADY b_TREADY o_TVALID o_TLAST bias_load mac_en busy done
  assign flagsA = {ifA.i_TREADY, ifA.k_TREADY, ifA.b_TREADY, ifA.o_TVALID,
                   ifA.o_TLAST, ifA.bias_load, ifA.mac_en, ifA.busy, ifA.done};
  assign flagsB = {ifB.i_TREADY, ifB.k_TREADY, ifB.b_TREADY, ifB.o_TVALID,
                   ifB.o_TLAST, ifB.bias_load, ifB.mac_en, ifB.busy, ifB.done};

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic iv, input logic kv,
                              input logic bv, input logic ordy,
                              input logic [8:0] flags, input int tap);
    vec_t v;
    v.start = s;
    v.iv    = iv;
    v.kv    = kv;
    v.bv    = bv;
    v.ordy  = ordy;
    v.flags = flags;
    v.tap   = tap;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushJob();
    for (int k = 0; k < NumOutA; k++) begin
      sbQ.push_back(k == NumOutA - 1);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    ifA.start    = v.start;
    ifA.i_TVALID = v.iv;
    ifA.k_TVALID = v.kv;
    ifA.b_TVALID = v.bv;
    ifA.o_TREADY = v.ordy;
    if (v.start && !v.flags[1]) begin
      pushJob();
    end
  endtask

  // Output monitor for instance A: every result handshake must match the
  // oldest expected o_TLAST.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (reset === 1'b0 && ifA.o_TVALID === 1'b1 && ifA.o_TREADY === 1'b1) begin
        hsA++;
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected: got output beat, expected none");
        end else begin
          checkOutput("sb_tlast", 32'(ifA.o_TLAST), 32'(sbQ.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] taps[$];
    logic        gotDone;
    int          doneCnt;
    int          hsStart;

    ifA.start = 0; ifA.i_TVALID = 0; ifA.k_TVALID = 0; ifA.b_TVALID = 0; ifA.o_TREADY = 0;
    ifB.start = 0; ifB.i_TVALID = 1; ifB.k_TVALID = 1; ifB.b_TVALID = 1; ifB.o_TREADY = 1;
    reset = 1'b1;

    // Basic two-output job with everything flowing.
    vecs.push_back(mk(1, 1, 1, 1, 1, F_IDLE, -1));
    for (int o = 0; o < 2; o++) begin
      vecs.push_back(mk(0, 1, 1, 1, 1, F_BIAS, -1));
      for (int t = 0; t < 3; t++) vecs.push_back(mk(0, 1, 1, 1, 1, F_MAC, t));
      vecs.push_back(mk(0, 1, 1, 1, 1, F_DRAIN, -1));
      vecs.push_back(mk(0, 1, 1, 1, 1, F_DRAIN, -1));
      vecs.push_back(mk(0, 1, 1, 1, 1, (o == 1) ? F_OUTL : F_OUT, -1));
    end
    vecs.push_back(mk(0, 1, 1, 1, 1, F_DONE, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_IDLE, -1));

    // Kernel valid toggling in MAC, then five back-pressured OUT cycles.
    vecs.push_back(mk(1, 1, 0, 1, 0, F_IDLE, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, F_BIAS, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, F_MAC, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, F_MACW, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, F_MAC, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0, F_MACW, 2));
    vecs.push_back(mk(0, 1, 1, 1, 0, F_MAC, 2));
    vecs.push_back(mk(0, 1, 0, 1, 0, F_DRAIN, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, F_DRAIN, -1));
    for (int s = 0; s < 5; s++) vecs.push_back(mk(0, 1, 1, 1, 0, F_OUT, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_OUT, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_BIAS, -1));
    for (int t = 0; t < 3; t++) vecs.push_back(mk(0, 1, 1, 1, 1, F_MAC, t));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_DRAIN, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_DRAIN, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_OUTL, -1));
    vecs.push_back(mk(0, 1, 1, 1, 1, F_DONE, -1));

    #12;
    checkOutput("reset_flagsA", 32'(flagsA), 32'(F_IDLE));
    checkOutput("reset_tapA", 32'(ifA.tap_idx), 32'd0);
    checkOutput("reset_flagsB", 32'(flagsB), 32'(F_IDLE));
`ifdef STALL_CNT_EN
    checkOutput("reset_stall", ifA.stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d_flags", i), 32'(flagsA), 32'(vecs[i].flags));
      if (vecs[i].tap >= 0) begin
        checkOutput($sformatf("vec%0d_tap", i), 32'(ifA.tap_idx), 32'(vecs[i].tap));
      end
    end
`ifdef STALL_CNT_EN
    checkOutput("stall_cycles", ifA.stall_cycles, 32'd7);
`endif
    @(negedge clk);
    checkOutput("table_handshakes", 32'(hsA), 32'd4);
    checkOutput("table_sb_empty", 32'(sbQ.size()), 32'd0);

    // Reset in the third MAC cycle, after two of three taps.
    ifA.i_TVALID = 1; ifA.k_TVALID = 1; ifA.b_TVALID = 1; ifA.o_TREADY = 1;
    ifA.start = 1;
    pushJob();
    @(negedge clk);
    ifA.start = 0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_pre_tap", 32'(ifA.tap_idx), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("rst_flags", 32'(flagsA), 32'(F_IDLE));
    checkOutput("rst_tap", 32'(ifA.tap_idx), 32'd0);
    sbQ.delete();
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("rst_after_flags", 32'(flagsA), 32'(F_IDLE));
    @(negedge clk);
    ifA.start = 1;
    pushJob();
    @(negedge clk);
    ifA.start = 0;
    gotDone = 0;
    for (int c = 0; c < 40 && !gotDone; c++) begin
      @(negedge clk);
      #2;
      if (ifA.mac_en) taps.push_back(ifA.tap_idx);
      if (ifA.done) gotDone = 1;
    end
    checkOutput("rst_job_done", 32'(gotDone), 32'd1);
    checkOutput("rst_mac_count", 32'(taps.size()), 32'd6);
    for (int k = 0; k < taps.size() && k < 6; k++) begin
      checkOutput($sformatf("rst_tap%0d", k), 32'(taps[k]), 32'(k % 3));
    end

    // start pulsed during DRAIN must not disturb the running job.
    @(negedge clk);
    hsStart = hsA;
    ifA.start = 1;
    pushJob();
    @(negedge clk);
    ifA.start = 0;
    repeat (4) @(negedge clk);
    #2;
    checkOutput("drain_flags", 32'(flagsA), 32'(F_DRAIN));
    ifA.start = 1;
    @(negedge clk);
    ifA.start = 0;
    gotDone = 0;
    doneCnt = 0;
    for (int c = 0; c < 40 && !gotDone; c++) begin
      @(negedge clk);
      #2;
      if (ifA.done) begin
        gotDone = 1;
        doneCnt++;
      end
    end
    checkOutput("drain_job_done", 32'(gotDone), 32'd1);
    repeat (5) begin
      @(negedge clk);
      #2;
      if (ifA.done) doneCnt++;
    end
    checkOutput("drain_done_count", 32'(doneCnt), 32'd1);
    checkOutput("drain_handshakes", 32'(hsA - hsStart), 32'd2);
    checkOutput("drain_idle_busy", 32'(ifA.busy), 32'd0);
    checkOutput("drain_sb_empty", 32'(sbQ.size()), 32'd0);

    // Shortest job on instance B: BIAS, MAC, OUT on consecutive cycles.
    @(negedge clk);
    ifB.start = 1;
    #2;
    checkOutput("b_idle", 32'(flagsB), 32'(F_IDLE));
    @(negedge clk);
    ifB.start = 0;
    #2;
    checkOutput("b_bias", 32'(flagsB), 32'(F_BIAS));
    @(negedge clk);
    #2;
    checkOutput("b_mac", 32'(flagsB), 32'(F_MAC));
    checkOutput("b_tap", 32'(ifB.tap_idx), 32'd0);
    @(negedge clk);
    #2;
    checkOutput("b_out_last", 32'(flagsB), 32'(F_OUTL));
    @(negedge clk);
    #2;
    checkOutput("b_done", 32'(flagsB), 32'(F_DONE));
    @(negedge clk);
    #2;
    checkOutput("b_idle_after", 32'(flagsB), 32'(F_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
